// File: rtl/audio_stereo_packer.sv
// Pairs an interleaved L/R mono sample stream into stereo frames with valid/ready on both sides.
// Channel-order faults (stray right, repeated left) are dropped/overwritten, pulsed and counted.
module audio_stereo_packer #(
    parameter int audio_width       = 32,
    parameter int error_count_width = 8
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic                         i_is_left,
    input  logic [audio_width-1:0]       i_audio,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [audio_width-1:0]       o_left,
    output logic [audio_width-1:0]       o_right,
    output logic                         o_sync_error,
    output logic [error_count_width-1:0] o_error_count
);

    typedef enum logic {HOLD_EMPTY = 1'b0, HOLD_LEFT = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [audio_width-1:0]         left_hold_q, left_hold_d;
    logic                           o_valid_q, o_valid_d;
    logic [audio_width-1:0]         o_left_q, o_left_d;
    logic [audio_width-1:0]         o_right_q, o_right_d;
    logic                           sync_error_q, sync_error_d;
    logic [error_count_width-1:0]   error_count_q, error_count_d;

    logic have_left;
    logic in_xfer;
    logic out_xfer;
    logic fault;
    logic frame_wr;

    assign have_left = (state_q == HOLD_LEFT);
    // Stall only when a right sample could need the output slot; applied to left too for uniformity.
    assign i_ready   = !(have_left && o_valid_q && !o_ready);
    assign in_xfer   = i_valid && i_ready;
    assign out_xfer  = o_valid_q && o_ready;

    always_comb begin
        state_d     = state_q;
        left_hold_d = left_hold_q;
        fault       = 1'b0;
        frame_wr    = 1'b0;
        if (in_xfer) begin
            if (i_is_left) begin
                left_hold_d = i_audio;
                state_d     = HOLD_LEFT;
                fault       = have_left;
            end else if (have_left) begin
                frame_wr = 1'b1;
                state_d  = HOLD_EMPTY;
            end else begin
                fault = 1'b1;
            end
        end
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_left_d  = o_left_q;
        o_right_d = o_right_q;
        // A new frame written during a drain keeps the slot occupied.
        if (frame_wr) begin
            o_valid_d = 1'b1;
            o_left_d  = left_hold_q;
            o_right_d = i_audio;
        end else if (out_xfer) begin
            o_valid_d = 1'b0;
        end
    end

    always_comb begin
        sync_error_d  = fault;
        error_count_d = error_count_q;
        if (fault && (error_count_q != {error_count_width{1'b1}}))
            error_count_d = error_count_q + error_count_width'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= HOLD_EMPTY;
            left_hold_q   <= '0;
            o_valid_q     <= 1'b0;
            o_left_q      <= '0;
            o_right_q     <= '0;
            sync_error_q  <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            left_hold_q   <= left_hold_d;
            o_valid_q     <= o_valid_d;
            o_left_q      <= o_left_d;
            o_right_q     <= o_right_d;
            sync_error_q  <= sync_error_d;
            error_count_q <= error_count_d;
        end
    end

    assign o_valid       = o_valid_q;
    assign o_left        = o_left_q;
    assign o_right       = o_right_q;
    assign o_sync_error  = sync_error_q;
    assign o_error_count = error_count_q;

endmodule

// File: tb/tb_audio_stereo_packer.sv
// Bench for audio_stereo_packer: directed table, hand sequences and random traffic
// against a queue-based frame model; a second instance with a 2-bit counter checks saturation.
module tb_audio_stereo_packer;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_is_left = 1'b0;
    logic [31:0] i_audio = '0;
    logic        o_ready = 1'b0;

    logic        i_ready, o_valid, o_sync_error;
    logic [31:0] o_left, o_right;
    logic [7:0]  o_error_count;

    logic        i_ready2, o_valid2, o_sync_error2;
    logic [31:0] o_left2, o_right2;
    logic [1:0]  o_error_count2;

    always #5 clk = ~clk;

    audio_stereo_packer #(.audio_width(32), .error_count_width(8)) dut (
        .clk(clk), .nreset(nreset), .i_valid(i_valid), .i_ready(i_ready),
        .i_is_left(i_is_left), .i_audio(i_audio), .o_valid(o_valid), .o_ready(o_ready),
        .o_left(o_left), .o_right(o_right), .o_sync_error(o_sync_error),
        .o_error_count(o_error_count)
    );

    audio_stereo_packer #(.audio_width(32), .error_count_width(2)) dut2 (
        .clk(clk), .nreset(nreset), .i_valid(i_valid), .i_ready(i_ready2),
        .i_is_left(i_is_left), .i_audio(i_audio), .o_valid(o_valid2), .o_ready(o_ready),
        .o_left(o_left2), .o_right(o_right2), .o_sync_error(o_sync_error2),
        .o_error_count(o_error_count2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a pending left (0 or 1 entries), the queue of frames not yet taken
    // downstream, total faults since reset, and whether the last edge saw a fault.
    typedef struct { logic [31:0] l; logic [31:0] r; } frame_t;
    logic [31:0] held_q[$];
    frame_t      frames_q[$];
    int          faults;
    logic        fault_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_clear();
        held_q.delete();
        frames_q.delete();
        faults     = 0;
        fault_last = 1'b0;
    endtask

    // Drive one cycle of inputs, check i_ready, advance the model, then check registered outputs.
    task automatic step(input logic v, input logic l, input logic [31:0] d, input logic r);
        logic rdy_exp, in_x;
        frame_t f;
        i_valid = v; i_is_left = l; i_audio = d; o_ready = r;
        #1;
        rdy_exp = !(held_q.size() != 0 && frames_q.size() != 0 && !r);
        chk("i_ready", i_ready, rdy_exp);
        chk("i_ready2", i_ready2, rdy_exp);
        in_x = v && rdy_exp;
        fault_last = 1'b0;
        if (frames_q.size() != 0 && r) void'(frames_q.pop_front());
        if (in_x) begin
            if (l) begin
                if (held_q.size() != 0) begin
                    fault_last = 1'b1;
                    held_q.delete();
                end
                held_q.push_back(d);
            end else if (held_q.size() != 0) begin
                f.l = held_q.pop_front();
                f.r = d;
                frames_q.push_back(f);
            end else begin
                fault_last = 1'b1;
            end
        end
        if (fault_last) faults++;
        @(posedge clk);
        #1;
        chk("o_valid", o_valid, frames_q.size() != 0);
        if (frames_q.size() != 0) begin
            chk("o_left", o_left, frames_q[0].l);
            chk("o_right", o_right, frames_q[0].r);
        end
        chk("o_sync_error", o_sync_error, fault_last);
        chk("o_error_count", o_error_count, 64'(sat(faults, 255)));
        chk("o_sync_error2", o_sync_error2, fault_last);
        chk("o_error_count2", o_error_count2, 64'(sat(faults, 3)));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        i_valid = 1'b0;
        o_ready = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        chk("rst o_valid", o_valid, 1'b0);
        chk("rst o_left", o_left, 32'h0);
        chk("rst o_right", o_right, 32'h0);
        chk("rst o_sync_error", o_sync_error, 1'b0);
        chk("rst o_error_count", o_error_count, 8'h0);
        chk("rst i_ready", i_ready, 1'b1);
        chk("rst o_error_count2", o_error_count2, 2'h0);
        #10;
        nreset = 1'b1;
        model_clear();
    endtask

    typedef struct {
        logic v; logic l; logic [31:0] d; logic r;
        logic e_rdy; logic e_v; logic [31:0] e_l; logic [31:0] e_r;
        logic e_err; logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[9];
    int   low_ready;
    int   pulses2;
    int   nfr;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h11111111, 32'h22222222, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 1'b0, 32'h5, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 8'd1};
        vecs[4] = '{1'b1, 1'b1, 32'hA, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'd1};
        vecs[5] = '{1'b1, 1'b1, 32'hB, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 8'd2};
        vecs[6] = '{1'b1, 1'b0, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB, 32'hC, 1'b0, 8'd2};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hB, 32'hC, 1'b0, 8'd2};
        vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 8'd2};

        model_clear();
        do_reset();

        // Directed table: basic frame, then R, L=A, L=B, R=C fault sequence.
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].r);
            chk($sformatf("tbl%0d o_valid", i), o_valid, vecs[i].e_v);
            if (vecs[i].e_v) begin
                chk($sformatf("tbl%0d o_left", i), o_left, vecs[i].e_l);
                chk($sformatf("tbl%0d o_right", i), o_right, vecs[i].e_r);
            end
            chk($sformatf("tbl%0d o_sync_error", i), o_sync_error, vecs[i].e_err);
            chk($sformatf("tbl%0d o_error_count", i), o_error_count, vecs[i].e_cnt);
        end

        // Continuous 8-frame stream: i_ready never drops, o_valid high after each R.
        do_reset();
        low_ready = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 32'h1000 + 32'(k), 1'b1);
            if (!i_ready) low_ready++;
            step(1'b1, 1'b0, 32'h2000 + 32'(k), 1'b1);
            if (!i_ready) low_ready++;
            chk("stream o_valid", o_valid, 1'b1);
            chk("stream o_left", o_left, 32'h1000 + 32'(k));
        end
        chk("stream i_ready lows", 64'(low_ready), 64'd0);

        // Backpressure: frame pending and stalled, L accepted, R held off until o_ready.
        do_reset();
        step(1'b1, 1'b1, 32'h1, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0);
        step(1'b1, 1'b1, 32'h3, 1'b0);
        i_valid = 1'b1; i_is_left = 1'b0; i_audio = 32'h4; o_ready = 1'b0;
        #1;
        chk("bp i_ready low", i_ready, 1'b0);
        step(1'b1, 1'b0, 32'h4, 1'b0);
        chk("bp old left held", o_left, 32'h1);
        chk("bp old right held", o_right, 32'h2);
        step(1'b1, 1'b0, 32'h4, 1'b1);
        chk("bp new frame left", o_left, 32'h3);
        chk("bp new frame right", o_right, 32'h4);
        chk("bp new frame valid", o_valid, 1'b1);

        // Saturation on the 2-bit instance.
        do_reset();
        pulses2 = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 32'($urandom), 1'b1);
            if (o_sync_error2) pulses2++;
        end
        chk("sat count", o_error_count2, 2'd3);
        chk("sat pulses", 64'(pulses2), 64'd5);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("sat hold", o_error_count2, 2'd3);
        chk("sat wide count", o_error_count, 8'd5);

        // Reset with a held left and a pending frame, then R, L, R.
        do_reset();
        step(1'b1, 1'b1, 32'hAA, 1'b0);
        step(1'b1, 1'b0, 32'hBB, 1'b0);
        step(1'b1, 1'b1, 32'hCC, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 32'hD1, 1'b1);
        step(1'b1, 1'b1, 32'hD2, 1'b1);
        step(1'b1, 1'b0, 32'hD3, 1'b1);
        chk("post-rst count", o_error_count, 8'd1);
        chk("post-rst left", o_left, 32'hD2);
        chk("post-rst right", o_right, 32'hD3);

        // Random traffic against the model.
        do_reset();
        nfr = 0;
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 5),
                 32'($urandom), 1'($urandom_range(0, 2) != 0));
            if (o_valid) nfr++;
        end
        chk("random produced frames", 64'(nfr > 0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
